// File: rtl/nonrestoring_div_if.sv
// Byte-serial bus shared with the Booth multiplier: operands stream in on inbus,
// and the quotient and remainder stream out on outbus. endsig marks the last byte.
interface nonrestoring_div_if #(parameter int N = 8);
  // Protocol: beginsig is taken only in IDLE while locksig=0. Each later byte is taken on
  // one non-locked cycle. locksig=1 freezes the block wherever it is, and outputs hold.
  logic         beginsig;
  logic         locksig;
  logic [N-1:0] inbus;
  logic [N-1:0] outbus;
  logic         endsig;
  logic         ovfsig;

  modport master (output beginsig, locksig, inbus, input outbus, endsig, ovfsig);
  modport slave  (input beginsig, locksig, inbus, output outbus, endsig, ovfsig);
endinterface

// File: rtl/nonrestoring_div.sv
// Sequential unsigned non-restoring divider (2N/N -> N quotient, N remainder) on a byte-serial bus.
// Optional DIV_OVF_EN: detects divide overflow or zero divisor in LOAD_DIV and returns all-ones with ovfsig.
module nonrestoring_div #(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  nonrestoring_div_if.slave        bus,
  output logic [2:0]               dbg_state
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_LO  = 3'd1,
    LOAD_DIV = 3'd2,
    CALC     = 3'd3,
    FIX      = 3'd4,
    OUT_Q    = 3'd5,
    OUT_R    = 3'd6
  } state_t;

  state_t         state, state_nxt;
  logic [N:0]     a_q;
  logic [N-1:0]   q_q;
  logic [N-1:0]   m_q;
  logic [CW-1:0]  cnt_q;
  logic [N:0]     a_shift;
  logic [N:0]     a_calc;
  logic           hold;
  logic           accept;
  logic           ovf_hit;
  logic           ovf_q;

  assign hold   = bus.locksig && (state != IDLE);
  assign accept = (state == IDLE) && bus.beginsig && !bus.locksig;

  // The sign of the partial remainder decides whether this step subtracts or adds back M.
  assign a_shift = {a_q[N-1:0], q_q[N-1]};
  assign a_calc  = a_q[N] ? (a_shift + {1'b0, m_q}) : (a_shift - {1'b0, m_q});

`ifdef DIV_OVF_EN
  assign ovf_hit = (bus.inbus == '0) || (a_q[N-1:0] >= bus.inbus);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           ovf_q <= 1'b0;
    else if (!hold && state == LOAD_DIV)  ovf_q <= ovf_hit;
  end
`else
  assign ovf_hit = 1'b0;
  assign ovf_q   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!hold) begin
      case (state)
        IDLE:     if (accept) state_nxt = LOAD_LO;
        LOAD_LO:  state_nxt = LOAD_DIV;
        LOAD_DIV: state_nxt = ovf_hit ? OUT_Q : CALC;
        CALC:     if (cnt_q == CW'(N - 1)) state_nxt = FIX;
        FIX:      state_nxt = OUT_Q;
        OUT_Q:    state_nxt = OUT_R;
        OUT_R:    state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else if (!hold) begin
      case (state)
        IDLE:     if (accept) a_q <= {1'b0, bus.inbus};
        LOAD_LO:  q_q <= bus.inbus;
        LOAD_DIV: begin
          m_q   <= bus.inbus;
          cnt_q <= '0;
          if (ovf_hit) begin
            q_q <= '1;
            a_q <= {1'b0, {N{1'b1}}};
          end
        end
        CALC: begin
          a_q   <= a_calc;
          q_q   <= {q_q[N-2:0], ~a_calc[N]};
          cnt_q <= cnt_q + CW'(1);
        end
        FIX:      if (a_q[N]) a_q <= a_q + {1'b0, m_q};
        default:  ;
      endcase
    end
  end

  always_comb begin
    bus.outbus = '0;
    bus.endsig = 1'b0;
    bus.ovfsig = 1'b0;
    case (state)
      OUT_Q: begin
        bus.outbus = q_q;
        bus.ovfsig = ovf_q;
      end
      OUT_R: begin
        bus.outbus = a_q[N-1:0];
        bus.endsig = 1'b1;
        bus.ovfsig = ovf_q;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_nonrestoring_div.sv
// Directed bench for nonrestoring_div: hand-computed quotient/remainder, latency, lock and reset cases.
module tb_nonrestoring_div;
  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         n_cmp;
  int         n_bad;
  int         cyc;

  nonrestoring_div_if #(.N(8)) bus ();

  nonrestoring_div #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives the three operand bytes; returns one cycle after LOAD_DIV with cyc = 3.
  task automatic start(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] dv);
    bus.beginsig = 1'b1;
    bus.inbus    = hi;
    step();
    bus.beginsig = 1'b0;
    bus.inbus    = lo;
    step();
    bus.inbus    = dv;
    step();
    bus.inbus    = 8'h00;
    cyc          = 3;
  endtask

  // Waits for endsig and checks quotient (the cycle before), remainder, latency and ovfsig.
  task automatic run_check(input string tag, input logic [7:0] eq, input logic [7:0] er,
                           input int eend, input logic eovf, input bit chk_val, input bit lock_r);
    logic [7:0] prev_out;
    logic       prev_ovf;
    bit         seen;
    prev_out = 8'h00;
    prev_ovf = 1'b0;
    seen     = 1'b0;
    while (!seen && cyc < 60) begin
      if (bus.endsig) seen = 1'b1;
      else begin
        prev_out = bus.outbus;
        prev_ovf = bus.ovfsig;
        step();
        cyc++;
      end
    end
    check_eq({tag, "_done"}, 32'(seen), 32'd1);
    if (seen) begin
      check_eq({tag, "_end_cyc"}, cyc, eend);
      if (chk_val) begin
        check_eq({tag, "_quot"}, prev_out, eq);
        check_eq({tag, "_rem"}, bus.outbus, er);
      end
      check_eq({tag, "_ovf_q"}, prev_ovf, eovf);
      check_eq({tag, "_ovf_r"}, bus.ovfsig, eovf);
      if (lock_r) begin
        bus.locksig = 1'b1;
        step();
        cyc++;
        check_eq({tag, "_end_locked"}, bus.endsig, 1'b1);
        check_eq({tag, "_rem_locked"}, bus.outbus, er);
        bus.locksig = 1'b0;
      end
      step();
      cyc++;
      check_eq({tag, "_end_drop"}, bus.endsig, 1'b0);
      check_eq({tag, "_out_idle"}, bus.outbus, 8'h00);
      check_eq({tag, "_idle"}, dbg_state, 3'd0);
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    bus.beginsig = 1'b0;
    bus.locksig  = 1'b0;
    bus.inbus    = 8'h00;
    #12;
    check_eq("rst_out", bus.outbus, 8'h00);
    check_eq("rst_end", bus.endsig, 1'b0);
    check_eq("rst_ovf", bus.ovfsig, 1'b0);
    check_eq("rst_state", dbg_state, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // basic vectors, issued back to back at the earliest legal cycle
    start(8'h00, 8'h64, 8'h07);
    run_check("d100_7", 8'h0E, 8'h02, 13, 1'b0, 1'b1, 1'b0);
    start(8'h12, 8'h34, 8'h40);
    run_check("d1234_40", 8'h48, 8'h34, 13, 1'b0, 1'b1, 1'b0);
    start(8'hFE, 8'hFF, 8'hFF);
    run_check("dfeff_ff", 8'hFF, 8'hFE, 13, 1'b0, 1'b1, 1'b0);
    start(8'h00, 8'h07, 8'h07);
    run_check("d7_7", 8'h01, 8'h00, 13, 1'b0, 1'b1, 1'b0);
    start(8'h00, 8'h05, 8'h09);
    run_check("d5_9", 8'h00, 8'h05, 13, 1'b0, 1'b1, 1'b0);

    // locksig in IDLE blocks beginsig
    bus.locksig  = 1'b1;
    bus.beginsig = 1'b1;
    bus.inbus    = 8'h33;
    step();
    check_eq("idle_lock_state", dbg_state, 3'd0);
    bus.locksig  = 1'b0;
    bus.beginsig = 1'b0;

    // lock 3 cycles in CALC with beginsig noise, then 1 cycle in OUT_R
    start(8'h00, 8'h64, 8'h07);
    step();
    step();
    cyc          = 5;
    bus.locksig  = 1'b1;
    bus.beginsig = 1'b1;
    bus.inbus    = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step();
      cyc++;
    end
    bus.locksig  = 1'b0;
    check_eq("lock_calc_out", bus.outbus, 8'h00);
    step();
    cyc++;
    bus.beginsig = 1'b0;
    bus.inbus    = 8'h00;
    run_check("lock", 8'h0E, 8'h02, 16, 1'b0, 1'b1, 1'b1);

    // async reset mid-CALC
    start(8'h00, 8'h64, 8'h07);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out", bus.outbus, 8'h00);
    check_eq("midrst_end", bus.endsig, 1'b0);
    check_eq("midrst_state", dbg_state, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start(8'h00, 8'h64, 8'h07);
    run_check("after_rst", 8'h0E, 8'h02, 13, 1'b0, 1'b1, 1'b0);

`ifdef DIV_OVF_EN
    start(8'h05, 8'h00, 8'h03);
    run_check("ovf_big", 8'hFF, 8'hFF, 4, 1'b1, 1'b1, 1'b0);
    start(8'h00, 8'h10, 8'h00);
    run_check("ovf_zero", 8'hFF, 8'hFF, 4, 1'b1, 1'b1, 1'b0);
    start(8'h00, 8'h64, 8'h07);
    run_check("ovf_clear", 8'h0E, 8'h02, 13, 1'b0, 1'b1, 1'b0);
`else
    start(8'h05, 8'h00, 8'h03);
    run_check("noovf_big", 8'h00, 8'h00, 13, 1'b0, 1'b0, 1'b0);
    start(8'h00, 8'h10, 8'h00);
    run_check("noovf_zero", 8'h00, 8'h00, 13, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nonrestoring_div.md
Name: nonrestoring_div

Overview:
- Sequential unsigned divider, the inverse of the radix-4 Booth multiplier datapath.
- Shares its byte-serial bus protocol: beginsig/locksig in, 8-bit inbus/outbus, endsig done strobe.
- Loads a 2N-bit dividend and an N-bit divisor over inbus, runs N non-restoring iterations, then returns quotient and remainder over outbus.
- Single FSM plus A/Q/M registers and an iteration counter, in one module.

Parameters:
- N, 8, operand/bus width. Dividend is 2N bits; divisor, quotient and remainder are N bits each. Iteration counter is clog2(N) bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- beginsig  input  1  start request; sampled only in IDLE
- locksig  input  1  stall; freezes FSM and datapath in every non-IDLE state
- inbus  input  N  operand bytes: dividend high, dividend low, divisor
- outbus  output  N  quotient in OUT_Q, remainder in OUT_R, 0 otherwise
- endsig  output  1  one-cycle strobe, high in OUT_R
- ovfsig  output  1  overflow flag; tied 0 unless DIV_OVF_EN

Behaviour:
- Reset (rst_n=0, async): state=IDLE; A (N+1 bits), Q, M and counter=0; outbus=0, endsig=0, ovfsig=0. Reset mid-operation aborts with no output and no endsig.
- IDLE: if beginsig=1 and locksig=0, A<={0,inbus} (dividend high), go to LOAD_LO. beginsig is ignored in all other states.
- LOAD_LO: Q<=inbus (dividend low), go to LOAD_DIV.
- LOAD_DIV: M<=inbus, counter<=0, go to CALC.
- CALC, one iteration per cycle:
  - shift {A,Q} left by 1.
  - If the old A[N]=0, A<=A_shift-M; otherwise A<=A_shift+M. Arithmetic is N+1 bits, two's complement, and wraps.
  - Q[0]<=~A_new[N]; counter++.
  - After the Nth iteration (counter==N-1), go to FIX.
- FIX: if A[N]=1, A<=A+M. Go to OUT_Q.
- OUT_Q: outbus=Q, go to OUT_R.
- OUT_R: outbus=A[N-1:0], endsig=1, go to IDLE.
- outbus is decoded from the state register and the data registers. It is 0 in every state except OUT_Q/OUT_R.
- locksig=1 in any non-IDLE state:
  - no register changes and inbus is not sampled;
  - outbus/endsig hold their current-state values, so endsig stays high while locked in OUT_R;
  - total latency stretches by exactly the number of locked cycles.
- Latency, N=8, no lock: beginsig accepted at cycle 0.
  - LOAD_LO at cycle 1, LOAD_DIV at 2, CALC at 3..10, FIX at 11.
  - OUT_Q at 12, OUT_R/endsig at 13.
  - A new beginsig is accepted at cycle 14 at the earliest.
- Valid range: dividend_hi < divisor, divisor != 0. Outside this range, without the optional feature, results are deterministic but unspecified and are not checked.
- Simultaneous events: rst_n has priority over everything. locksig has priority over beginsig and over state advance.

Optional Feature:
- Macro: DIV_OVF_EN.
- Defined:
  - In LOAD_DIV, compare inbus against A[N-1:0]. If inbus==0 or A[N-1:0]>=inbus, go directly to OUT_Q and skip CALC/FIX.
  - Set Q to all ones and A[N-1:0] to all ones, so both outbus bytes read as all ones.
  - ovfsig=1 in OUT_Q and OUT_R; it is 0 in every other state.
  - Overflow latency for N=8: OUT_Q at cycle 3, endsig at cycle 4.
- Undefined: no comparator is built, ovfsig is constant 0, and every operand pair runs the full N iterations.

Test Plan:
- 0x00,0x64 / 0x07 -> outbus 0x0E at cycle 12, 0x02 with endsig=1 at cycle 13, ovfsig=0.
- 0x12,0x34 / 0x40 -> quotient 0x48, remainder 0x34.
- 0xFE,0xFF / 0xFF -> quotient 0xFF, remainder 0xFE (boundary: max valid dividend for divisor 0xFF).
- 0x00,0x64 / 0x07 with locksig=1 for 3 cycles during CALC and 1 cycle in OUT_R -> same 0x0E/0x02; endsig rises at cycle 16 and stays high 2 cycles. beginsig pulses during CALC are ignored.
- rst_n=0 at cycle 6 (mid-CALC) -> outbus=0 and endsig=0 immediately; a following 0x00,0x64 / 0x07 run completes correctly with 0x0E/0x02.
- DIV_OVF_EN defined:
  - 0x05,0x00 / 0x03 -> outbus 0xFF, 0xFF with ovfsig=1 at cycles 3-4, endsig at cycle 4.
  - 0x00,0x10 / 0x00 -> same overflow response.
  - Without the macro, the first case completes at cycle 13 with ovfsig=0.
